bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential double-dabble binary-to-BCD converter. Converts an unsigned
//  parameter/level value into packed BCD nibbles that feed per-digit
//  hex-to-7-segment decoders on the board display. Has a start/busy/done
//  handshake. Output digits update only at completion, so the display never
//  shows intermediate values.
// PARAMETERS
//  WIDTH   16  bit width of the unsigned binary input
//  DIGITS  5   number of BCD output digits (digit 0 = least significant)
// PORTS
//  clk      in   1          system clock; all state on the rising edge
//  rst_n    in   1          asynchronous active-low reset
//  start    in   1          request conversion; sampled only in IDLE
//  bin_in   in   WIDTH      value to convert; captured on an accepted start
//  busy     out  1          high while a conversion is in progress (SHIFT, DONE)
//  done     out  1          one-cycle pulse: bcd_out/overflow are new
//  bcd_out  out  4*DIGITS   packed BCD; [4i+3:4i] = digit i; held between updates
//  overflow out  1          last result did not fit in DIGITS digits
//  blank    out  DIGITS     per-digit blank request (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset:
//  - Reset is asynchronous active-low on clk.
//  - While rst_n=0: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, blank=0,
//    working registers=0.
//  - Reset asserted mid-conversion aborts the conversion. No done pulse is
//    produced. Outputs return to their reset values.
//  States:
//  - IDLE: start=1 -> load shift reg with bin_in, BCD work reg=0, ovf_work=0,
//    cnt=WIDTH; go to SHIFT. start=0 -> stay in IDLE.
//  - SHIFT: each cycle, every work digit >=5 gets +3. Then shift
//    {carry,BCD,bin} left by 1. ovf_work |= bit shifted out of the top digit.
//    cnt decrements. When cnt reaches 1 on this cycle, go to DONE.
//    Exactly WIDTH SHIFT cycles occur.
//  - DONE: done=1 for this single cycle, then go to IDLE unconditionally.
//  Output update and timing:
//  - bcd_out, overflow and blank are registered on the SHIFT->DONE edge.
//    They are valid in the cycle where done=1.
//  - Latency: start sampled at edge k -> done high in cycle k+WIDTH+1.
//    busy is high in cycles k+1..k+WIDTH+1.
//    Back-to-back throughput: one conversion per WIDTH+2 cycles.
//  Boundary conditions:
//  - start while busy (SHIFT or DONE) is ignored and not queued.
//  - bin_in changes after acceptance have no effect.
//  - Overflow (value >= 10^DIGITS): overflow=1 and every digit of bcd_out
//    saturates to 9 (display shows all nines).
//  - Fit: overflow=0 and bcd_out holds the exact value.
//  - bin_in=0 -> bcd_out=0, overflow=0.
//  - Adjusted digit values never exceed 4'hF. The add-3 is done at 4-bit width.
//    The carry from each digit's top bit feeds the next digit's LSB via the shift.
// CONFIGURATION
//  Macro: BIN2BCD_LZ_BLANK_EN
//  - Defined: blank[i]=1 iff i>0 and digit i and all digits above it are zero
//    in the updated bcd_out. blank[0] is always 0, so value 0 shows a single "0".
//    overflow=1 forces blank=0.
//  - Not defined: blank is tied to 0. The port still exists, so instantiation
//    is identical in both builds.
// TESTING
//  Run all scenarios with WIDTH=16, DIGITS=5 unless stated.
//  1. Reset, start with bin_in=16'd0 -> done exactly 17 cycles after the start
//     edge; bcd_out=20'h00000, overflow=0; busy high for 17 cycles.
//  2. bin_in=16'd65535 -> bcd_out=20'h65535, overflow=0.
//     bin_in=16'd1234 -> bcd_out=20'h01234.
//  3. DIGITS=4, bin_in=16'd12345 -> overflow=1, bcd_out=16'h9999.
//     bin_in=16'd9999 -> overflow=0, bcd_out=16'h9999.
//  4. start held high continuously, bin_in alternating 7/8 -> conversions
//     every 18 cycles. Values that change mid-conversion are ignored.
//     bcd_out stays stable between done pulses.
//  5. rst_n pulsed low 5 cycles into a conversion of 16'd500 -> no done,
//     bcd_out=0. The next start of 16'd42 completes normally with 20'h00042.
//  6. With BIN2BCD_LZ_BLANK_EN: 16'd42 -> blank=5'b11100; 16'd0 -> 5'b11110;
//     overflow case -> 5'b00000. Without the macro: blank=0 always.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bin_sr;
    logic [BW-1:0]     bcd_w;
    logic              ovf_w;
    logic [CW-1:0]     cnt;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     bcd_nxt;
    logic [BW-1:0]     bcd_fin;
    logic              ovf_nxt;
    logic [DIGITS-1:0] blank_fin;

    // Add-3 at 4-bit width, then shift; the top digit's MSB falls off as overflow.
    always_comb begin
        adj = bcd_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_w[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
        end
        bcd_nxt = {adj[BW-2:0], bin_sr[WIDTH-1]};
        ovf_nxt = ovf_w | adj[BW-1];
        bcd_fin = ovf_nxt ? {DIGITS{4'h9}} : bcd_nxt;
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic zrun;

    always_comb begin
        blank_fin = '0;
        zrun      = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zrun         = zrun & (bcd_fin[4*i +: 4] == 4'd0);
            blank_fin[i] = zrun & ~ovf_nxt;
        end
    end
`else
    assign blank_fin = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_w    <= '0;
            ovf_w    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            blank    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        bcd_w  <= '0;
                        ovf_w  <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_sr <= bin_sr << 1;
                    bcd_w  <= bcd_nxt;
                    ovf_w  <= ovf_nxt;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        bcd_out  <= bcd_fin;
                        overflow <= ovf_nxt;
                        blank    <= blank_fin;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (5-digit and 4-digit instances).
// Blank expectations follow BIN2BCD_LZ_BLANK_EN.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;

    logic        start4;
    logic [15:0] bin4;
    logic        busy4;
    logic        done4;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [3:0]  blank4;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd), .overflow(ovf),
        .blank(blank)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4),
        .blank(blank4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run5(input logic [15:0] v, output int lat, output int bcnt);
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        bcnt = 0;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat  = c;
                seen = 1;
            end
        end
    endtask

    task automatic run4(input logic [15:0] v, output int lat);
        bit seen;
        @(negedge clk);
        start4 = 1'b1;
        bin4   = v;
        @(posedge clk);
        #1 start4 = 1'b0;
        lat  = -1;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (done4) begin
                lat  = c;
                seen = 1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        start4 = 1'b0;
        bin4   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, bcd, ovf, blank} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {busy, done, bcd, ovf, blank});
        end
        checks++;
        if ({busy4, done4, bcd4, ovf4, blank4} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs4 got %h want 0",
                     {busy4, done4, bcd4, ovf4, blank4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat;
        int bcnt;
        run5(16'd0, lat, bcnt);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL zero_latency got %0d want 17", lat);
        end
        checks++;
        if (bcnt !== 17) begin
            errors++;
            $display("FAIL zero_busy_cycles got %0d want 17", bcnt);
        end
        checks++;
        if (bcd !== 20'h00000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_value got %h/%b want 00000/0", bcd, ovf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_values;
        int lat;
        int bcnt;
        run5(16'd65535, lat, bcnt);
        checks++;
        if (lat !== 17 || bcd !== 20'h65535 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL max_value got lat=%0d %h/%b want 17 65535/0",
                     lat, bcd, ovf);
        end
        run5(16'd1234, lat, bcnt);
        checks++;
        if (lat !== 17 || bcd !== 20'h01234 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL v1234 got lat=%0d %h/%b want 17 01234/0",
                     lat, bcd, ovf);
        end
    endtask

    task automatic test_overflow;
        int lat;
        run4(16'd12345, lat);
        checks++;
        if (lat !== 17 || bcd4 !== 16'h9999 || ovf4 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_12345 got lat=%0d %h/%b want 17 9999/1",
                     lat, bcd4, ovf4);
        end
        run4(16'd9999, lat);
        checks++;
        if (lat !== 17 || bcd4 !== 16'h9999 || ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL fit_9999 got lat=%0d %h/%b want 17 9999/0",
                     lat, bcd4, ovf4);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] pend;
        logic [19:0] last;
        int          ndone;
        int          prev;
        int          stab_err;
        ndone    = 0;
        prev     = -1;
        stab_err = 0;
        pend     = 16'd7;
        last     = bcd;
        @(negedge clk);
        start  = 1'b1;
        bin_in = pend;
        for (int c = 0; c < 200 && ndone < 4; c++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (bcd !== {4'h0, 4'h0, 4'h0, 4'h0, pend[3:0]}) begin
                    errors++;
                    $display("FAIL b2b_value got %h want %h", bcd, pend);
                end
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 18) begin
                        errors++;
                        $display("FAIL b2b_period got %0d want 18", c - prev);
                    end
                end
                prev  = c;
                last  = bcd;
                pend  = (pend == 16'd7) ? 16'd8 : 16'd7;
                ndone++;
            end else begin
                if (bcd !== last) stab_err++;
                bin_in = busy ? 16'd999 : pend;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", ndone);
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL b2b_stable got %0d changes want 0", stab_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int lat;
        int bcnt;
        int ndone;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd500;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bcd, ovf, blank} !== 27'd0) begin
            errors++;
            $display("FAIL abort_outputs got %h want 0",
                     {busy, done, bcd, ovf, blank});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || bcd !== 20'h0) begin
            errors++;
            $display("FAIL abort_no_done got %0d dones bcd=%h want 0/00000",
                     ndone, bcd);
        end
        run5(16'd42, lat, bcnt);
        checks++;
        if (lat !== 17 || bcd !== 20'h00042 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_abort got lat=%0d %h/%b want 17 00042/0",
                     lat, bcd, ovf);
        end
    endtask

    task automatic test_blank;
        int          lat;
        int          bcnt;
        logic [4:0]  e42;
        logic [4:0]  e0;
`ifdef BIN2BCD_LZ_BLANK_EN
        e42 = 5'b11100;
        e0  = 5'b11110;
`else
        e42 = 5'b00000;
        e0  = 5'b00000;
`endif
        run5(16'd42, lat, bcnt);
        checks++;
        if (blank !== e42) begin
            errors++;
            $display("FAIL blank_42 got %b want %b", blank, e42);
        end
        run5(16'd0, lat, bcnt);
        checks++;
        if (blank !== e0) begin
            errors++;
            $display("FAIL blank_0 got %b want %b", blank, e0);
        end
        run4(16'd0, lat);
        run4(16'd12345, lat);
        checks++;
        if (blank4 !== 4'b0000 || ovf4 !== 1'b1) begin
            errors++;
            $display("FAIL blank_ovf got %b/%b want 0000/1", blank4, ovf4);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
